// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding, the
// memory-side request bundle and the starvation counter helper.
// The bundle widths below set the arbiter's ADDR_WIDTH/DATA_WIDTH defaults.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_WIDTH = 32;
    localparam int ARB_DATA_WIDTH = 32;
    localparam int ARB_BE_WIDTH   = ARB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } ArbState_t;

    // Captured winner request; doubles as the registered memory-side bundle.
    typedef struct packed {
        logic                      req;
        logic                      we;
        logic [ARB_BE_WIDTH-1:0]   be;
        logic [ARB_ADDR_WIDTH-1:0] addr;
        logic [ARB_DATA_WIDTH-1:0] wdata;
    } MemPortReq_t;

    // Saturating increment used for the instruction starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] limit);
        return (cnt >= limit) ? limit : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_watchdog.sv
// Grant watchdog: counts grant cycles without mem_ack and flags a timeout
// in the cycle the count reaches TIMEOUT_CYCLES-1. Only used when the
// arbiter is built with ARB_TIMEOUT_EN.
module mem_port_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_ack,
    output logic o_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Counter is held at zero outside a grant, so every grant starts from 0.
    always_ff @(posedge clk) begin
        if (!rst || !i_active) begin
            r_cnt <= '0;
        end else if (!i_ack && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_timeout = i_active && !i_ack && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single external memory port (IF + MEM stages).
// Data requests win unless instruction fetch has waited STARVE_LIMIT data
// grants. One transaction in flight; each grant is followed by a DONE cycle.
// Optional watchdog: define ARB_TIMEOUT_EN to abort grants after
// TIMEOUT_CYCLES cycles without mem_ack (bus_err pulse, rdata 0).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_req,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    output logic                    inst_ack,
    input  logic                    data_req,
    input  logic                    data_we,
    input  logic [DATA_WIDTH/8-1:0] data_be,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_ack,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    grant_data,
    output logic                    bus_err,
    output ArbState_t               dbg_state
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    ArbState_t             r_state;
    MemPortReq_t           r_mem;
    logic [3:0]            r_starve_cnt;
    logic [DATA_WIDTH-1:0] r_inst_rdata;
    logic [DATA_WIDTH-1:0] r_data_rdata;

    logic                  w_in_grant;
    logic                  w_pick_data;
    logic                  w_timeout;
    logic                  w_mem_done;
    logic [DATA_WIDTH-1:0] w_ack_rdata;

    assign w_in_grant  = (r_state == GNT_I) || (r_state == GNT_D);
    // Data wins unless instruction fetch is pending and already starved.
    assign w_pick_data = data_req && !(inst_req && (r_starve_cnt == LIMIT));

`ifdef ARB_TIMEOUT_EN
    mem_port_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_active  (w_in_grant),
        .i_ack     (mem_ack),
        .o_timeout (w_timeout)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout = 1'b0;
`endif

    // A grant ends on mem_ack or, with the watchdog, on timeout.
    assign w_mem_done  = w_in_grant && (mem_ack || w_timeout);
    // A timed-out transaction returns zero data.
    assign w_ack_rdata = mem_ack ? mem_rdata : '0;

    // Arbitration FSM, captured request bundle and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_mem        <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!inst_req) begin
                        r_starve_cnt <= '0;
                    end
                    if (w_pick_data) begin
                        r_state <= GNT_D;
                        r_mem   <= '{req: 1'b1, we: data_we, be: data_be,
                                     addr: data_addr, wdata: data_wdata};
                        if (inst_req) begin
                            r_starve_cnt <= starve_inc(r_starve_cnt, LIMIT);
                        end
                    end else if (inst_req) begin
                        r_state      <= GNT_I;
                        r_mem        <= '{req: 1'b1, we: 1'b0, be: {ARB_BE_WIDTH{1'b1}},
                                          addr: inst_addr, wdata: '0};
                        r_starve_cnt <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (w_mem_done) begin
                        r_state   <= DONE;
                        r_mem.req <= 1'b0;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Hold the last completion data so rdata stays stable after the ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (inst_ack) r_inst_rdata <= w_ack_rdata;
            if (data_ack) r_data_rdata <= w_ack_rdata;
        end
    end

    assign inst_ack   = (r_state == GNT_I) && w_mem_done;
    assign data_ack   = (r_state == GNT_D) && w_mem_done;
    assign inst_rdata = inst_ack ? w_ack_rdata : r_inst_rdata;
    assign data_rdata = data_ack ? w_ack_rdata : r_data_rdata;

    assign mem_req    = r_mem.req;
    assign mem_we     = r_mem.we;
    assign mem_be     = r_mem.be;
    assign mem_addr   = r_mem.addr;
    assign mem_wdata  = r_mem.wdata;
    assign grant_data = (r_state == GNT_D);
    assign bus_err    = w_in_grant && w_timeout && !mem_ack;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// from both requesters and a randomly-latent memory responder.
// Build with ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;
  localparam int TMO   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic [DW-1:0] inst_rdata;
  logic          inst_ack;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [BW-1:0] data_be = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] data_rdata;
  logic          data_ack;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          grant_data;
  logic          bus_err;
  ArbState_t     dbg_state;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant_data(grant_data), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // ---------------- memory responder ----------------
  bit            rand_mode  = 1'b0;
  bit            hold_ack   = 1'b0;
  int            next_lat   = 0;
  logic [DW-1:0] next_rdata = '0;
  bit            in_txn     = 1'b0;
  bit            ack_given  = 1'b0;
  int            wcnt       = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (rand_mode) mem_rdata = $urandom;
      if (mem_req && !ack_given) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt   = rand_mode ? int'($urandom_range(0, 3)) : next_lat;
        end
        if (!hold_ack) begin
          if (wcnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = rand_mode ? $urandom : next_rdata;
            ack_given = 1'b1;
          end else begin
            wcnt--;
          end
        end
      end else if (!mem_req) begin
        in_txn    = 1'b0;
        ack_given = 1'b0;
        // Stray acks outside a grant must be ignored by the arbiter.
        if (rand_mode && ($urandom_range(0, 7) == 0)) mem_ack = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks "port free / busy / cooling down" and how many data grants
  // instruction fetch has watched go by; pushes the expected grant and
  // completion for every transaction it predicts.
  typedef struct packed {
    logic          who;   // 1 = data
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [31:0]   cyc;
  } gnt_t;

  typedef struct packed {
    logic          who;
    logic [DW-1:0] rdata;
    logic [31:0]   cyc;
  } ack_t;

  gnt_t exp_gnt_q[$];
  ack_t exp_ack_q[$];

  int   m_phase  = 0;    // 0 free, 1 busy, 2 cooling down
  logic m_who    = 1'b0;
  int   m_streak = 0;
  int   m_wait   = 0;
  logic e_req    = 1'b0;
  logic e_gd     = 1'b0;
  logic e_err    = 1'b0;

  always @(negedge clk) begin
    e_req = (m_phase == 1);
    e_gd  = (m_phase == 1) && m_who;
    e_err = 1'b0;
    if (!rst) begin
      m_phase  = 0;
      m_streak = 0;
      exp_ack_q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (data_req && !(inst_req && (m_streak >= LIMIT))) begin
            exp_gnt_q.push_back('{1'b1, data_we, data_be, data_addr, data_wdata, cyc + 1});
            m_streak = inst_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
            m_who    = 1'b1;
            m_phase  = 1;
            m_wait   = 0;
          end else if (inst_req) begin
            exp_gnt_q.push_back('{1'b0, 1'b0, {BW{1'b1}}, inst_addr, {DW{1'b0}}, cyc + 1});
            m_streak = 0;
            m_who    = 1'b0;
            m_phase  = 1;
            m_wait   = 0;
          end else begin
            m_streak = 0;
          end
        end
        1: begin
          if (mem_ack) begin
            exp_ack_q.push_back('{m_who, mem_rdata, cyc});
            m_phase = 2;
          end
`ifdef ARB_TIMEOUT_EN
          else if (m_wait == TMO - 1) begin
            exp_ack_q.push_back('{m_who, {DW{1'b0}}, cyc});
            e_err   = 1'b1;
            m_phase = 2;
          end else begin
            m_wait++;
          end
`endif
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_req = 1'b0;
  gnt_t g;
  ack_t a;

  always @(negedge clk) begin
    #1;
    check("mem_req_level", mem_req, e_req);
    check("grant_data_level", grant_data, e_gd);
    check("bus_err_level", bus_err, e_err);
    check("single_ack", inst_ack & data_ack, 1'b0);
    if (mem_req && !prev_req) begin
      if (exp_gnt_q.size() == 0) begin
        fail_now("grant_unexpected", "mem_req rose with no predicted grant");
      end else begin
        g = exp_gnt_q.pop_front();
        check("grant_cycle", cyc, g.cyc);
        check("grant_owner", grant_data, g.who);
        check("grant_we", mem_we, g.we);
        check("grant_be", mem_be, g.be);
        check("grant_addr", mem_addr, g.addr);
        if (g.who) check("grant_wdata", mem_wdata, g.wdata);
      end
    end
    if (inst_ack || data_ack) begin
      if (exp_ack_q.size() == 0) begin
        fail_now("ack_unexpected", "ack with no predicted completion");
      end else begin
        a = exp_ack_q.pop_front();
        check("ack_owner", data_ack, a.who);
        check("ack_cycle", cyc, a.cyc);
        check("ack_rdata", a.who ? data_rdata : inst_rdata, a.rdata);
      end
    end
    prev_req = mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input bit is_data, input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (is_data ? data_ack : inst_ack) break;
      n++;
      if (n >= 400) begin
        fail_now(tag, "no ack within 400 cycles");
        break;
      end
    end
  endtask

  task automatic inst_txn(input logic [AW-1:0] addr);
    tick();
    inst_req  = 1'b1;
    inst_addr = addr;
    wait_ack(1'b0, "inst_ack_timeout");
    tick();
    inst_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [BW-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    tick();
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wdata;
    wait_ack(1'b1, "data_ack_timeout");
    tick();
    data_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int nd;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_acks", {inst_ack, data_ack}, 2'b00);
    check("rst_grant_bus_err", {grant_data, bus_err}, 2'b00);
    check("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
    check("rst_mem_bundle", {mem_we, mem_be, mem_addr}, 64'h0);
    check("rst_state", dbg_state, IDLE);

    // Reset while a data read is waiting for mem_ack.
    hold_ack = 1'b1;
    tick();
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h8000_2000;
    repeat (3) @(negedge clk);
    check("rstmid_granted", {mem_req, grant_data}, 2'b11);
    tick();
    rst = 1'b0;
    data_req = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_outputs", {mem_req, inst_ack, data_ack, grant_data, bus_err}, 5'b0);
    check("rstmid_rdata", {inst_rdata, data_rdata}, 64'h0);
    check("rstmid_state", dbg_state, IDLE);
    hold_ack = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_ack) nd++;
    end
    check("rstmid_no_ack", nd, 0);

    // Single instruction read, memory answers two cycles into the grant.
    next_lat = 2; next_rdata = 32'h3C08_BFC0;
    tick();
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
    @(negedge clk);
    check("ifetch_req_at_N", mem_req, 1'b0);
    @(negedge clk);
    check("ifetch_req_at_N1", mem_req, 1'b1);
    check("ifetch_be", mem_be, 4'hF);
    check("ifetch_we", mem_we, 1'b0);
    check("ifetch_addr", mem_addr, 32'h1FC0_0000);
    n = 0;
    while (!inst_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ifetch_ack_delay", n, 2);
    check("ifetch_rdata", inst_rdata, 32'h3C08_BFC0);
    tick();
    inst_req = 1'b0;
    repeat (2) @(negedge clk);

    // Data write, memory answers in the first grant cycle.
    next_lat = 0; next_rdata = 32'h1234_5678;
    tick();
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h8000_1000; data_wdata = 32'h0000_BEEF;
    @(negedge clk);
    check("dwr_gd_at_N", grant_data, 1'b0);
    @(negedge clk);
    check("dwr_gd_at_N1", grant_data, 1'b1);
    check("dwr_ack_at_N1", data_ack, 1'b1);
    check("dwr_we", mem_we, 1'b1);
    check("dwr_be", mem_be, 4'b0011);
    check("dwr_wdata", mem_wdata, 32'h0000_BEEF);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    check("dwr_gd_at_N2", grant_data, 1'b0);
    check("dwr_req_at_N2", mem_req, 1'b0);
    repeat (2) @(negedge clk);

    // Both requesters held: four data grants, then instruction fetch.
    tick();
    inst_req = 1'b1; inst_addr = 32'h1FC0_0040;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h8000_0100;
    nd = 0;
    n  = 0;
    while (n < 200) begin
      @(negedge clk);
      if (inst_ack) break;
      if (data_ack) nd++;
      n++;
    end
    check("starve_data_first", nd, LIMIT);
    check("starve_inst_served", inst_ack, 1'b1);
    tick();
    inst_req = 1'b0;
    wait_ack(1'b1, "starve_data_after");
    tick();
    data_req = 1'b0;
    repeat (3) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // Data read that memory never answers.
    hold_ack = 1'b1;
    tick();
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h8000_3000;
    @(negedge clk);
    n = 0;
    while (!data_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tmo_delay", n, TMO);
    check("tmo_bus_err", bus_err, 1'b1);
    check("tmo_rdata", data_rdata, 32'h0);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    check("tmo_done", dbg_state, DONE);
    @(negedge clk);
    check("tmo_idle", dbg_state, IDLE);
    hold_ack = 1'b0;
`endif

    // Randomized traffic from both requesters.
    rand_mode = 1'b1;
    fork
      begin
        for (int k = 0; k < 120; k++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          inst_txn($urandom);
        end
      end
      begin
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          data_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
      end
    join
    rand_mode = 1'b0;
    repeat (6) @(negedge clk);
    check("gnt_queue_drained", exp_gnt_q.size(), 0);
    check("ack_queue_drained", exp_ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
